// File: rtl/keyframe_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keyframe_load_ctrl
// Purpose  : Loads the 86-bit key/frame store from PS/2 bytes and launches the
//            A5/1 cipher core. Optional frame auto-increment: KEYFRAME_AUTOINC_EN
// Revision : 1.0  initial release
// ============================================================================
module keyframe_load_ctrl #(
  parameter logic [7:0] ABORT_CODE  = 8'h76,
  parameter int         KEY_BYTES   = 8,
  parameter int         FRAME_BYTES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        cipher_done,
  output logic [7:0]  kf_data,
  output logic [2:0]  kf_index,
  output logic        kf_frame_sel,
  output logic        kf_we,
  output logic        cipher_start,
  output logic        busy,
  output logic [21:0] frame_num
);

  localparam logic [2:0] C_KEY_LAST   = 3'(KEY_BYTES - 1);
  localparam logic [2:0] C_FRAME_LAST = 3'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_KEY   = 3'd1,
    S_LOAD_FRAME = 3'd2,
    S_COMMIT     = 3'd3,
    S_RUN        = 3'd4
`ifdef KEYFRAME_AUTOINC_EN
    , S_REFRESH  = 3'd5
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [13:0] acc_q, acc_d;
  logic [21:0] frame_num_q, frame_num_d;
  logic [7:0]  kf_data_q, kf_data_d;
  logic [2:0]  kf_index_q, kf_index_d;
  logic        kf_sel_q, kf_sel_d;
  logic        kf_we_q, kf_we_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;

  logic w_abort;
  logic w_accept;

  assign w_abort  = byte_valid && (byte_in == ABORT_CODE);
  assign w_accept = byte_valid && (byte_in != ABORT_CODE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    frame_num_d = frame_num_q;
    kf_data_d   = kf_data_q;
    kf_index_d  = kf_index_q;
    kf_sel_d    = kf_sel_q;
    kf_we_d     = 1'b0;
    start_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          kf_we_d    = 1'b1;
          kf_data_d  = byte_in;
          kf_index_d = C_KEY_LAST;
          kf_sel_d   = 1'b0;
          cnt_d      = C_KEY_LAST - 3'd1;
          state_d    = S_LOAD_KEY;
        end
      end

      S_LOAD_KEY: begin
        if (w_abort) begin
          state_d = S_IDLE;
        end else if (w_accept) begin
          kf_we_d    = 1'b1;
          kf_data_d  = byte_in;
          kf_index_d = cnt_q;
          kf_sel_d   = 1'b0;
          if (cnt_q == 3'd0) begin
            cnt_d   = C_FRAME_LAST;
            state_d = S_LOAD_FRAME;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end

      S_LOAD_FRAME: begin
        if (w_abort) begin
          state_d = S_IDLE;
        end else if (w_accept) begin
          kf_we_d    = 1'b1;
          kf_data_d  = byte_in;
          kf_index_d = cnt_q;
          kf_sel_d   = 1'b1;
          // Bytes are staged so an abort never leaves a partial frame number.
          if (cnt_q == 3'd2) begin
            acc_d = {byte_in[5:0], 8'h00};
            cnt_d = cnt_q - 3'd1;
          end else if (cnt_q == 3'd1) begin
            acc_d = {acc_q[13:8], byte_in};
            cnt_d = cnt_q - 3'd1;
          end else begin
            frame_num_d = {acc_q, byte_in};
            cnt_d       = 3'd0;
            state_d     = S_COMMIT;
          end
        end
      end

      S_COMMIT: begin
        start_d = 1'b1;
        state_d = S_RUN;
      end

      S_RUN: begin
`ifdef KEYFRAME_AUTOINC_EN
        if (w_abort) begin
          state_d = S_IDLE;
        end else if (cipher_done) begin
          frame_num_d = frame_num_q + 22'd1;
          cnt_d       = C_FRAME_LAST;
          state_d     = S_REFRESH;
        end
`else
        if (cipher_done) begin
          state_d = S_IDLE;
        end
`endif
      end

`ifdef KEYFRAME_AUTOINC_EN
      S_REFRESH: begin
        if (w_abort) begin
          state_d = S_IDLE;
        end else begin
          kf_we_d    = 1'b1;
          kf_index_d = cnt_q;
          kf_sel_d   = 1'b1;
          case (cnt_q)
            3'd2:    kf_data_d = {2'b00, frame_num_q[21:16]};
            3'd1:    kf_data_d = frame_num_q[15:8];
            default: kf_data_d = frame_num_q[7:0];
          endcase
          if (cnt_q == 3'd0) begin
            state_d = S_COMMIT;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      acc_q       <= 14'd0;
      frame_num_q <= 22'd0;
      kf_data_q   <= 8'd0;
      kf_index_q  <= 3'd0;
      kf_sel_q    <= 1'b0;
      kf_we_q     <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      frame_num_q <= frame_num_d;
      kf_data_q   <= kf_data_d;
      kf_index_q  <= kf_index_d;
      kf_sel_q    <= kf_sel_d;
      kf_we_q     <= kf_we_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  assign kf_data      = kf_data_q;
  assign kf_index     = kf_index_q;
  assign kf_frame_sel = kf_sel_q;
  assign kf_we        = kf_we_q;
  assign cipher_start = start_q;
  assign busy         = busy_q;
  assign frame_num    = frame_num_q;

endmodule
`default_nettype wire

// File: tb/tb_keyframe_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keyframe_load_ctrl
// Purpose  : Scoreboard bench for keyframe_load_ctrl (store writes, start
//            pulses, busy and frame number).
// Revision : 1.0  initial release
// ============================================================================
module tb_keyframe_load_ctrl;

  localparam logic [7:0] C_ABORT = 8'h76;
  localparam int M_IDLE = 0, M_KEY = 1, M_FRAME = 2, M_COMMIT = 3, M_RUN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        cipher_done = 1'b0;
  logic [7:0]  kf_data;
  logic [2:0]  kf_index;
  logic        kf_frame_sel;
  logic        kf_we;
  logic        cipher_start;
  logic        busy;
  logic [21:0] frame_num;

  keyframe_load_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (byte_valid),
    .byte_in      (byte_in),
    .cipher_done  (cipher_done),
    .kf_data      (kf_data),
    .kf_index     (kf_index),
    .kf_frame_sel (kf_frame_sel),
    .kf_we        (kf_we),
    .cipher_start (cipher_start),
    .busy         (busy),
    .frame_num    (frame_num)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sel;
    logic [2:0] idx;
    logic [7:0] data;
    logic [31:0] stamp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_starts = 0;
  int exp_starts = 0;

  int          m_state = M_IDLE;
  logic [2:0]  m_cnt = 3'd0;
  logic [13:0] m_acc = 14'd0;
  logic [21:0] m_frame = 22'd0;
  int          m_start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void push_exp(logic sel, logic [2:0] idx, logic [7:0] d, int st);
    exp_t e;
    e.sel = sel; e.idx = idx; e.data = d; e.stamp = 32'(st);
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each store write must match the oldest expected write,
  // arriving exactly one cycle after the byte that caused it.
  always @(negedge clk) begin
    if (!reset && cipher_start) n_starts++;
    if (!reset && kf_we) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'(kf_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("kf_frame_sel", 32'(kf_frame_sel), 32'(mon_e.sel));
        check("kf_index", 32'(kf_index), 32'(mon_e.idx));
        check("kf_data", 32'(kf_data), 32'(mon_e.data));
        check("we_latency", 32'(cyc), mon_e.stamp + 32'd1);
      end
    end
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    cipher_done = 1'b0;
    case (m_state)
      M_IDLE: if (b != C_ABORT) begin
        push_exp(1'b0, 3'd7, b, cyc);
        m_cnt = 3'd6; m_state = M_KEY;
      end
      M_KEY: if (b == C_ABORT) m_state = M_IDLE;
      else begin
        push_exp(1'b0, m_cnt, b, cyc);
        if (m_cnt == 3'd0) begin m_state = M_FRAME; m_cnt = 3'd2; end
        else m_cnt = m_cnt - 3'd1;
      end
      M_FRAME: if (b == C_ABORT) m_state = M_IDLE;
      else begin
        push_exp(1'b1, m_cnt, b, cyc);
        if (m_cnt == 3'd2) m_acc = {b[5:0], 8'h00};
        else if (m_cnt == 3'd1) m_acc[7:0] = b;
        else begin
          m_frame = {m_acc, b};
          m_state = M_COMMIT;
          m_start_cyc = cyc + 2;
          exp_starts++;
        end
        m_cnt = m_cnt - 3'd1;
      end
      M_RUN: begin
`ifdef KEYFRAME_AUTOINC_EN
        if (b == C_ABORT) m_state = M_IDLE;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
      cipher_done = 1'b0;
    end
  endtask

  task automatic wait_start();
    bit found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      if (cipher_start) begin
        check("start_cycle", 32'(cyc), 32'(m_start_cyc));
        found = 1;
      end
    end
    if (!found) check("start_seen", 32'(cipher_start), 32'd1);
    @(negedge clk);
    check("start_width", 32'(cipher_start), 32'd0);
    m_state = M_RUN;
  endtask

  task automatic pulse_done();
    int s;
    @(negedge clk);
    byte_valid = 1'b0;
    cipher_done = 1'b1;
    s = cyc;
    if (m_state == M_RUN) begin
`ifdef KEYFRAME_AUTOINC_EN
      m_frame = m_frame + 22'd1;
      push_exp(1'b1, 3'd2, {2'b00, m_frame[21:16]}, s + 1);
      push_exp(1'b1, 3'd1, m_frame[15:8], s + 2);
      push_exp(1'b1, 3'd0, m_frame[7:0], s + 3);
      m_start_cyc = s + 5;
      exp_starts++;
      m_state = M_COMMIT;
`else
      m_state = M_IDLE;
`endif
    end
    @(negedge clk);
    cipher_done = 1'b0;
  endtask

  task automatic finish_run(input logic [21:0] exp_next);
    pulse_done();
    check("busy_after_done", 32'(busy), 32'(m_state != M_IDLE));
`ifdef KEYFRAME_AUTOINC_EN
    wait_start();
    check("frame_autoinc", 32'(frame_num), 32'(exp_next));
    drive(C_ABORT);
    wait_cycles(2);
    check("busy_after_run_abort", 32'(busy), 32'd0);
`else
    check("frame_hold", 32'(frame_num), 32'(m_frame));
    if (exp_next == m_frame) check("frame_no_inc", 32'(frame_num), 32'(exp_next));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] saved;
    // Reset state
    @(negedge clk);
    check("rst_kf_we", 32'(kf_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(cipher_start), 32'd0);
    check("rst_kf_data", 32'(kf_data), 32'd0);
    check("rst_frame_num", 32'(frame_num), 32'd0);
    reset = 1'b0;

    // Reset in the middle of the key load
    drive(8'hA1); drive(8'hA2); drive(8'hA3);
    wait_cycles(1);
    #2 reset = 1'b1;
    #1;
    check("midrst_kf_we", 32'(kf_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_kf_index", 32'(kf_index), 32'd0);
    check("midrst_kf_data", 32'(kf_data), 32'd0);
    exp_q.delete();
    m_state = M_IDLE;
    @(negedge clk);
    reset = 1'b0;

    // Full load of all-ones, back to back
    for (int i = 0; i < 11; i++) drive(8'hFF);
    wait_cycles(1);
    wait_start();
    check("frame_all_ones", 32'(frame_num), 32'h003F_FFFF);
    check("busy_in_run", 32'(busy), 32'd1);

    // Bytes during RUN are ignored
    drive(8'h12); drive(8'h34);
`ifndef KEYFRAME_AUTOINC_EN
    drive(C_ABORT);
`endif
    wait_cycles(3);
    check("run_no_writes", 32'(exp_q.size()), 32'd0);
    check("busy_run_hold", 32'(busy), 32'd1);
`ifdef KEYFRAME_AUTOINC_EN
    finish_run(22'h000000);
`else
    finish_run(22'h3FFFFF);
`endif

    // Stray cipher_done in IDLE
    pulse_done();
    wait_cycles(2);
    check("stray_done_busy", 32'(busy), 32'd0);
    check("stray_done_starts", 32'(n_starts), 32'(exp_starts));

    // Abort after 5 key bytes
    saved = m_frame;
    for (int i = 0; i < 5; i++) drive(8'(8'h10 + i));
    drive(C_ABORT);
    wait_cycles(2);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_frame_hold", 32'(frame_num), 32'(saved));

    // Lone abort code in IDLE does nothing
    drive(C_ABORT);
    wait_cycles(2);
    check("idle_abort_busy", 32'(busy), 32'd0);

    // Abort partway through the frame field keeps old frame number
    for (int i = 0; i < 8; i++) drive(8'(8'h20 + i));
    drive(8'hEE);
    drive(C_ABORT);
    wait_cycles(2);
    check("frame_abort_busy", 32'(busy), 32'd0);
    check("frame_abort_hold", 32'(frame_num), 32'(saved));

    // Frame assembly discards the top two bits of the first frame byte
    for (int i = 0; i < 8; i++) drive(8'(i * 17));
    drive(8'hC1); drive(8'h23); drive(8'h45);
    wait_cycles(1);
    wait_start();
    check("frame_assembly", 32'(frame_num), 32'h0001_2345);
`ifdef KEYFRAME_AUTOINC_EN
    finish_run(22'h012346);
`else
    finish_run(22'h012345);
`endif

    wait_cycles(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("start_count", 32'(n_starts), 32'(exp_starts));
    check("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keyframe_load_ctrl.md
Name: keyframe_load_ctrl

Overview:
- Sequences loading of the 86-bit key/frame store (64-bit session key + 22-bit frame number) from PS/2 byte strobes.
- Drives the store's byte data, slot index and write-enable.
- Hands a "loaded" start pulse to the A5/1 cipher core and waits for its done.
- Sits between the PS/2 byte receiver and the key/frame register + cipher core.

Parameters:
- ABORT_CODE, 8'h76, byte value that aborts loading and returns to IDLE (PS/2 Esc).
- KEY_BYTES, 8, number of key bytes loaded, index counts KEY_BYTES-1 down to 0.
- FRAME_BYTES, 3, number of frame bytes loaded, index counts FRAME_BYTES-1 down to 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- byte_valid  in  1  one-cycle strobe, byte_in is valid
- byte_in  in  8  PS/2 data byte
- cipher_done  in  1  one-cycle pulse from cipher core, run finished
- kf_data  out  8  byte to store, registered copy of accepted byte_in
- kf_index  out  3  slot index within current field
- kf_frame_sel  out  1  0 = key field, 1 = frame field
- kf_we  out  1  one-cycle write strobe to store
- cipher_start  out  1  one-cycle pulse: store complete, begin run
- busy  out  1  high from first accepted byte until return to IDLE
- frame_num  out  22  shadow of loaded frame number

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, byte counter=0, frame_num=0.
- IDLE:
  - byte_valid with byte_in!=ABORT_CODE: accept as key byte 7, go LOAD_KEY.
  - byte_valid with byte_in==ABORT_CODE: ignored.
- Write timing: every accepted byte produces kf_we=1 exactly one cycle after its byte_valid, with kf_data/kf_index/kf_frame_sel stable in that cycle. kf_we is 0 otherwise.
- LOAD_KEY: index counts 7,6,...,0. After the index-0 write, go LOAD_FRAME.
- LOAD_FRAME:
  - Index counts 2,1,0, kf_frame_sel=1.
  - frame_num assembly, MSB byte first: bits[21:16] = byte[5:0] of first frame byte (bits 7:6 discarded), then [15:8], then [7:0].
  - kf_data carries the raw byte.
  - After the index-0 write, go COMMIT.
- COMMIT: cipher_start=1 for exactly one cycle (cycle after final kf_we), go RUN.
- RUN:
  - Waits for cipher_done. byte_valid is ignored, including ABORT_CODE.
  - On cipher_done, go IDLE (busy falls the next cycle).
- Abort: byte_valid with ABORT_CODE in LOAD_KEY or LOAD_FRAME → IDLE next cycle. No kf_we for that byte. frame_num holds its old value (partial frame bytes are not committed to frame_num).
- byte_valid in COMMIT is dropped.
- cipher_done outside RUN is ignored.
- Back-to-back byte_valid on consecutive cycles must be accepted without loss.
- busy=1 in LOAD_KEY, LOAD_FRAME, COMMIT and RUN.

Optional Feature:
- Macro: KEYFRAME_AUTOINC_EN.
- Defined:
  - On cipher_done in RUN, frame_num increments mod 2^22 (3FFFFF wraps to 0) and state goes to REFRESH instead of IDLE.
  - REFRESH writes the 3 frame bytes from the new frame_num on 3 consecutive cycles: index 2,1,0, kf_frame_sel=1, first kf_data={2'b00,frame_num[21:16]}.
  - Then COMMIT, then RUN again.
  - ABORT_CODE during REFRESH or RUN → IDLE.
- Undefined: REFRESH does not exist; RUN returns to IDLE on cipher_done; frame_num is never incremented.

Test Plan:
- Reset: assert reset mid-LOAD_KEY (after 3 bytes) → same-cycle outputs 0, busy=0. Next load starts again at index 7.
- Full load: 11 bytes 8'hFF back-to-back → 8 kf_we with frame_sel=0, index 7..0; then 3 with frame_sel=1, index 2..0. frame_num=22'h3FFFFF. cipher_start one cycle after last kf_we.
- Abort: 5 key bytes then 8'h76 → no 6th kf_we, state IDLE, busy=0, frame_num unchanged. Idle 8'h76 alone → no activity.
- RUN gating: bytes during RUN → no kf_we. cipher_done → busy drops next cycle. Stray cipher_done in IDLE → no effect.
- Frame assembly: frame bytes 8'hC1, 8'h23, 8'h45 → frame_num=22'h012345.
- Autoinc (KEYFRAME_AUTOINC_EN): load frame 22'h3FFFFF, pulse cipher_done → frame_num=0, 3 kf_we with kf_data 00,00,00, then cipher_start again.
